// File: rtl/mse_batch_ctrl.sv
`timescale 1ns/1ps
// mse_batch_ctrl
// Mean-squared-error sequencer for a batch of signed Q8.8 (prediction, target)
// pairs. Squared errors (Q8.8) are summed into a saturating ACC_W-bit
// accumulator, then divided by the batch length with a restoring divider
// (one quotient bit per cycle, MSB first). The Q8.8 mean is offered on a
// valid/ready output, saturated to 0x7FFF.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high; the producer holds data stable while valid is high and ready is
// low; out_valid/loss/overflow stay stable until accepted.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start, n_samples  begin a batch (IDLE only); batch length latched on start
//   busy              high in every state except IDLE
//   in_valid/in_ready sample stream, y_pred / y_true signed Q8.8
//   out_valid/out_ready, loss (Q8.8, >= 0), overflow (saturation marker)
//   dbg_state         current FSM state for observation
module mse_batch_ctrl #(
    parameter int CNT_W = 8,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      y_pred,
    input  logic [15:0]      y_true,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      loss,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int DIV_CW = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DIV   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;      // sum during ACCUM, quotient during DIV
    logic                r_sat;
    logic [CNT_W-1:0]    r_rem;      // remainder is always < n, so CNT_W bits suffice
    logic [DIV_CW-1:0]   r_div_cnt;
    logic [15:0]         r_loss;
    logic                r_ovf;

    // Squared error datapath
    logic signed [16:0]  w_diff;
    logic signed [33:0]  w_diff_x;
    logic signed [33:0]  w_sq;
    logic [25:0]         w_e;
    logic [ACC_W:0]      w_sum;
    logic [ACC_W-1:0]    w_acc_next;
    logic                w_accept;
    logic                w_last;
    logic                w_div_done;

    // Restoring divider step
    logic [CNT_W:0]      w_rem_sh;
    logic                w_ge;
    logic [CNT_W:0]      w_rem_sub;
    logic                w_q_big;

    assign w_diff     = $signed({y_pred[15], y_pred}) - $signed({y_true[15], y_true});
    assign w_diff_x   = 34'(w_diff);
    assign w_sq       = w_diff_x * w_diff_x;   // |diff| <= 65535, so the square fits in 32 bits
    assign w_e        = w_sq[33:8];
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - 26){1'b0}}, w_e};
    assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    assign w_accept   = in_valid && in_ready;
    assign w_last     = w_accept && (r_cnt == r_n - 1'b1);
    assign w_div_done = (r_div_cnt == DIV_CW'(ACC_W));

    assign w_rem_sh   = {r_rem, r_acc[ACC_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_n});
    assign w_rem_sub  = w_rem_sh - {1'b0, r_n};
    assign w_q_big    = |r_acc[ACC_W-1:15];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = (n_samples == '0) ? S_DONE : S_ACCUM;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (w_last) w_next = S_DIV;
            end
            S_DIV: begin
                // ACC_W quotient-bit cycles, then one cycle to register the result
                if (w_div_done) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n       <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_rem     <= '0;
            r_div_cnt <= '0;
            r_loss    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n    <= n_samples;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_sat  <= 1'b0;
                        r_loss <= '0;
                        r_ovf  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_sat <= r_sat | w_sum[ACC_W];
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_rem     <= '0;
                            r_div_cnt <= '0;
                        end
                    end
                end
                S_DIV: begin
                    if (!w_div_done) begin
                        // Dividend bits shift out of the top while quotient bits enter the bottom
                        r_acc     <= {r_acc[ACC_W-2:0], w_ge};
                        r_rem     <= w_ge ? w_rem_sub[CNT_W-1:0] : w_rem_sh[CNT_W-1:0];
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end else begin
                        r_loss <= w_q_big ? 16'h7FFF : r_acc[15:0];
                        r_ovf  <= w_q_big | r_sat;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_loss <= '0;
                        r_ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign loss      = r_loss;
    assign overflow  = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mse_batch_ctrl.sv
`timescale 1ns/1ps
module tb_mse_batch_ctrl;
    localparam int CNT_W = 8;
    localparam int ACC_W = 40;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_samples = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      y_pred = '0;
    logic [15:0]      y_true = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      loss;
    logic             overflow;
    logic [1:0]       dbg_state;

    int checks = 0;
    int failures = 0;

    // Scoreboard: {overflow, loss}
    logic [16:0] exp_q[$];
    longint m_sum;
    bit     m_sat;
    int     m_n;
    bit     ready_seen;

    mse_batch_ctrl #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .y_pred(y_pred), .y_true(y_true),
        .out_valid(out_valid), .out_ready(out_ready), .loss(loss), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    always @(negedge clk) if (in_ready) ready_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model
    task automatic model_begin(input int n);
        m_sum = 0;
        m_sat = 1'b0;
        m_n   = n;
    endtask

    task automatic model_add(input logic [15:0] p, input logic [15:0] t);
        longint d;
        longint e;
        d = longint'($signed(p)) - longint'($signed(t));
        e = (d * d) >> 8;
        m_sum = m_sum + e;
        if (m_sum > ACC_MAX) begin
            m_sum = ACC_MAX;
            m_sat = 1'b1;
        end
    endtask

    task automatic model_push();
        longint q;
        logic [15:0] l;
        logic o;
        q = (m_n == 0) ? 0 : m_sum / m_n;
        l = (q > 32767) ? 16'h7FFF : q[15:0];
        o = (q > 32767) || m_sat;
        exp_q.push_back({o, l});
    endtask

    // Drivers
    task automatic do_start(input int n);
        model_begin(n);
        n_samples = CNT_W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] p, input logic [15:0] t, input int bubbles);
        int cyc;
        repeat (bubbles) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        y_pred = p;
        y_true = t;
        cyc = 0;
        while (!in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            model_add(p, t);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Waits for the loss, compares against the scoreboard, optionally stalls.
    task automatic get_result(input string tag, input int exp_lat, input int hold);
        int cyc;
        logic [16:0] e;
        cyc = 0;
        while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
        if (!out_valid) begin
            check({tag, "_timeout"}, 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_loss"}, loss, e[15:0]);
        check({tag, "_ovf"}, overflow, e[16]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_loss"}, {overflow, loss}, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_clear"}, out_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_loss", loss, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single sample (4.0, 2.0)
        do_start(1);
        check("single_busy", busy, 1);
        check("single_in_ready", in_ready, 1);
        send_sample(16'h0400, 16'h0200, 0);
        check("single_ready_drop", in_ready, 0);
        model_push();
        get_result("single", ACC_W + 1, 0);
        check("single_exp", {1'b0, 16'h0400}, 17'h00400);

        // Batch of 3 with bubbles, held under backpressure
        do_start(3);
        send_sample(16'h0400, 16'h0200, 0);
        send_sample(16'h0100, 16'h0000, 2);
        send_sample(16'h0080, 16'h0100, 2);
        model_push();
        check("batch3_model", exp_q[0], 17'h001C0);
        get_result("batch3", ACC_W + 1, 10);

        // start pulsed mid-ACCUM must not change the batch length
        do_start(2);
        send_sample(16'h0300, 16'h0100, 0);
        n_samples = 8'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("guard_busy", busy, 1);
        check("guard_in_ready", in_ready, 1);
        send_sample(16'hFF00, 16'h0000, 1);
        model_push();
        get_result("guard", ACC_W + 1, 0);

        // Saturation
        do_start(1);
        send_sample(16'h7FFF, 16'h8000, 0);
        model_push();
        get_result("sat", ACC_W + 1, 0);
        check("sat_loss_direct", 17'(loss), 17'h00000);

        // Zero length
        ready_seen = 1'b0;
        model_begin(0);
        model_push();
        n_samples = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_valid_next", out_valid, 1);
        get_result("zero", 0, 2);
        check("zero_no_ready", ready_seen, 0);

        // Asynchronous reset during DIV
        do_start(1);
        send_sample(16'h0400, 16'h0100, 0);
        repeat (5) @(posedge clk);
        #3;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        check("arst_loss", loss, 0);
        check("arst_ovf", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(1);
        send_sample(16'h0200, 16'h0200, 0);
        model_push();
        get_result("post_rst", ACC_W + 1, 0);

        // Random batches
        for (int b = 0; b < 4; b++) begin
            int n;
            n = $urandom_range(1, 6);
            do_start(n);
            for (int s = 0; s < n; s++) begin
                send_sample(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                            $urandom_range(0, 2));
            end
            model_push();
            get_result($sformatf("rand%0d", b), ACC_W + 1, $urandom_range(0, 3));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
